// File: rtl/imem_loader_if.sv
// Bus interfaces for the instruction-memory loader: the incoming byte stream
// (valid/ready) and the word-wide instruction-memory write port.

interface byte_stream_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);
endinterface

interface imem_wr_if #(
  parameter int ADDR_W = 10
);
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wr_data;

  modport master (output imem_wr_en, output imem_addr, output imem_wr_data);
  modport slave  (input  imem_wr_en, input  imem_addr, input  imem_wr_data);
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian byte image,
// writes it word by word from address 0, and releases the CPU once complete.

module imem_loader #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  byte_stream_if.slave  bs,
  imem_wr_if.master     imem,
  output logic          cpu_reset_n,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);

  localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  localparam logic [16:0]       DEPTH_L  = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [15:0]       len_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [IDLE_W-1:0] idle_q;
  logic [15:0]       words_q;
  logic              byte_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wr_data_q;
  logic              cpu_rst_n_q;
  logic              done_q;
  logic              error_q;

  logic        xfer;
  logic [15:0] len_n;
  logic [15:0] words_inc;

  assign xfer      = bs.byte_valid && byte_ready_q;
  assign len_n     = {bs.byte_data, len_q[7:0]};
  assign words_inc = words_q + 16'd1;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; the async reset branch returns everything to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      idle_q       <= '0;
      words_q      <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LEN_LO;
            byte_ready_q <= 1'b1;
            idle_q       <= '0;
            words_q      <= '0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end
        end
        S_LEN_LO, S_LEN_HI, S_DATA: begin
          if (!xfer) begin
            // A stalled stream aborts the load; a partial word is simply dropped.
            if (idle_q == IDLE_MAX) begin
              state_q      <= S_ERR;
              error_q      <= 1'b1;
              byte_ready_q <= 1'b0;
              idle_q       <= '0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end else begin
            idle_q <= '0;
            if (state_q == S_LEN_LO) begin
              len_q[7:0] <= bs.byte_data;
              state_q    <= S_LEN_HI;
            end else if (state_q == S_LEN_HI) begin
              len_q[15:8] <= bs.byte_data;
              if (len_n == 16'd0 || {1'b0, len_n} > DEPTH_L) begin
                state_q      <= S_ERR;
                error_q      <= 1'b1;
                byte_ready_q <= 1'b0;
              end else begin
                state_q    <= S_DATA;
                byte_idx_q <= '0;
              end
            end else begin
              unique case (byte_idx_q)
                2'd0: word_q[7:0]   <= bs.byte_data;
                2'd1: word_q[15:8]  <= bs.byte_data;
                2'd2: word_q[23:16] <= bs.byte_data;
                default: begin
                  state_q      <= S_WRITE;
                  byte_ready_q <= 1'b0;
                  wr_en_q      <= 1'b1;
                  addr_q       <= words_q[ADDR_W-1:0];
                  wr_data_q    <= {bs.byte_data, word_q};
                end
              endcase
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          words_q <= words_inc;
          if (words_inc == len_q) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            cpu_rst_n_q <= 1'b1;
          end else begin
            state_q      <= S_DATA;
            byte_ready_q <= 1'b1;
            byte_idx_q   <= '0;
            idle_q       <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bs.byte_ready     = byte_ready_q;
  assign imem.imem_wr_en   = wr_en_q;
  assign imem.imem_addr    = addr_q;
  assign imem.imem_wr_data = wr_data_q;
  assign cpu_reset_n       = cpu_rst_n_q;
  assign done              = done_q;
  assign error             = error_q;
  assign words_loaded      = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image loads, length errors, stall timeout,
// mid-load reset and start handling, with expected writes hand-computed.

module tb_imem_loader;

  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpu_reset_n;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  byte_stream_if             bs ();
  imem_wr_if #(.ADDR_W(ADDR_W)) im ();

  imem_loader #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .bs           (bs),
    .imem         (im),
    .cpu_reset_n  (cpu_reset_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W+31:0] wq[$];
  logic [31:0]        img[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe; the stream must be stalled while writing.
  always @(negedge clk) begin
    if (im.imem_wr_en === 1'b1) begin
      wq.push_back({im.imem_addr, im.imem_wr_data});
      check("ready_low_in_write", 64'(bs.byte_ready), 64'd0);
    end
  end

  // Every task below starts and ends on a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int budget;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    budget        = 50;
    while (bs.byte_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("byte_accept", 64'(bs.byte_ready), 64'd1);
    @(negedge clk);
    bs.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], rnd);
  endtask

  task automatic send_image(input logic [15:0] n, input bit rnd);
    send_byte(n[7:0], rnd);
    send_byte(n[15:8], rnd);
    foreach (img[i]) send_word(img[i], rnd);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 64'(wq.size()), 64'(img.size()));
    foreach (img[i]) begin
      if (i < wq.size()) check({tag, "_write"}, 64'(wq[i]), 64'({ADDR_W'(i), img[i]}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;
    repeat (2) @(negedge clk);

    check("rst_byte_ready", 64'(bs.byte_ready), 64'd0);
    check("rst_wr_en", 64'(im.imem_wr_en), 64'd0);
    check("rst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(bs.byte_ready), 64'd0);

    // Two-word image, done one cycle after the second write.
    wq.delete();
    pulse_start();
    check("t1_ready_after_start", 64'(bs.byte_ready), 64'd1);
    img = '{32'h0000_0013, 32'h0010_0093};
    send_image(16'd2, 1'b0);
    check("t1_wr_en", 64'(im.imem_wr_en), 64'd1);
    check("t1_done_in_write", 64'(done), 64'd0);
    @(negedge clk);
    check("t1_done", 64'(done), 64'd1);
    check("t1_cpu_released", 64'(cpu_reset_n), 64'd1);
    check("t1_words", 64'(words_loaded), 64'd2);
    check("t1_wr_en_off", 64'(im.imem_wr_en), 64'd0);
    check("t1_addr_hold", 64'(im.imem_addr), 64'd1);
    check("t1_data_hold", 64'(im.imem_wr_data), 64'h0010_0093);
    check_writes("t1");

    // One-word image with random gaps in byte_valid.
    wq.delete();
    pulse_start();
    check("t2_cpu_held", 64'(cpu_reset_n), 64'd0);
    check("t2_done_clr", 64'(done), 64'd0);
    check("t2_words_clr", 64'(words_loaded), 64'd0);
    img = '{32'hDEAD_BEEF};
    send_image(16'd1, 1'b1);
    @(negedge clk);
    check("t2_done", 64'(done), 64'd1);
    check_writes("t2");

    // Zero length.
    wq.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t3a_error", 64'(error), 64'd1);
    check("t3a_cpu_held", 64'(cpu_reset_n), 64'd0);
    check("t3a_ready", 64'(bs.byte_ready), 64'd0);
    @(negedge clk);
    check("t3a_no_write", 64'(wq.size()), 64'd0);

    // Length DEPTH+1.
    pulse_start();
    check("t3b_error_clr", 64'(error), 64'd0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t3b_error", 64'(error), 64'd1);

    // Length DEPTH: last write at DEPTH-1.
    wq.delete();
    pulse_start();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(32'hA5A5_0000 | 32'(i * 3));
    send_image(16'(DEPTH), 1'b0);
    check("t3c_wr_en", 64'(im.imem_wr_en), 64'd1);
    check("t3c_last_addr", 64'(im.imem_addr), 64'(DEPTH - 1));
    @(negedge clk);
    check("t3c_done", 64'(done), 64'd1);
    check("t3c_words", 64'(words_loaded), 64'(DEPTH));
    check_writes("t3c");

    // Stream stalls after two data bytes.
    wq.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("t4_no_error_early", 64'(error), 64'd0);
    @(negedge clk);
    check("t4_error", 64'(error), 64'd1);
    check("t4_cpu_held", 64'(cpu_reset_n), 64'd0);
    check("t4_no_write", 64'(wq.size()), 64'd0);

    // Reset in the middle of the third word.
    wq.delete();
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h33, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_ready", 64'(bs.byte_ready), 64'd0);
    check("t5_wr_en", 64'(im.imem_wr_en), 64'd0);
    check("t5_addr", 64'(im.imem_addr), 64'd0);
    check("t5_data", 64'(im.imem_wr_data), 64'd0);
    check("t5_cpu_held", 64'(cpu_reset_n), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_error", 64'(error), 64'd0);
    check("t5_words", 64'(words_loaded), 64'd0);
    check("t5_partial_writes", 64'(wq.size()), 64'd2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    pulse_start();
    img = '{32'hCAFE_F00D};
    send_image(16'd1, 1'b0);
    @(negedge clk);
    check("t5_reload_done", 64'(done), 64'd1);
    check_writes("t5");

    // start during DATA is ignored.
    wq.delete();
    pulse_start();
    img = '{32'h0102_0304, 32'h0506_0708};
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h03, 1'b0);
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'h0506_0708, 1'b0);
    @(negedge clk);
    check("t6_done", 64'(done), 64'd1);
    check("t6_words", 64'(words_loaded), 64'd2);
    check_writes("t6");

    // start in DONE drops the CPU reset on the next edge and reloads.
    check("t6_cpu_before", 64'(cpu_reset_n), 64'd1);
    wq.delete();
    pulse_start();
    check("t6_cpu_dropped", 64'(cpu_reset_n), 64'd0);
    check("t6_done_clr", 64'(done), 64'd0);
    check("t6_words_clr", 64'(words_loaded), 64'd0);
    img = '{32'h1234_5678};
    send_image(16'd1, 1'b0);
    @(negedge clk);
    check("t6_reload_done", 64'(done), 64'd1);
    check("t6_reload_cpu", 64'(cpu_reset_n), 64'd1);
    check("t6_reload_words", 64'(words_loaded), 64'd1);
    check_writes("t6r");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
